// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin arbiter sharing the single-port data memory between two requesters
// Optional feature macro: DM_ARB_LOCK_EN (adds lock0/lock1 to keep priority with the current owner)
module dm_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef DM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic prio;
    logic owner;
    logic lat_we;
    logic gnt_any;
    logic gnt_sel;
    logic lock_own;

    // Port 1 wins when it is the only requester or when both request and it holds priority.
    always_comb begin
        gnt_any = req0 | req1;
        gnt_sel = req1 & (~req0 | prio);
    end

`ifdef DM_ARB_LOCK_EN
    always_comb begin
        lock_own = owner ? lock1 : lock0;
    end
`else
    always_comb begin
        lock_own = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (gnt_any) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode from state only, so an asynchronous reset drops dm_wr at once.
    always_comb begin
        ack0  = 1'b0;
        ack1  = 1'b0;
        busy  = 1'b0;
        dm_wr = 1'b0;
        case (state)
            ST_ACCESS: begin
                busy  = 1'b1;
                dm_wr = lat_we;
            end
            ST_RESP: begin
                busy = 1'b1;
                ack0 = ~owner;
                ack1 = owner;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // dm_addr/dm_din double as the latched request, so they hold outside ACCESS.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner   <= 1'b0;
            lat_we  <= 1'b0;
            dm_addr <= '0;
            dm_din  <= '0;
        end else if (state == ST_IDLE && gnt_any) begin
            owner   <= gnt_sel;
            lat_we  <= gnt_sel ? we1 : we0;
            dm_addr <= gnt_sel ? addr1 : addr0;
            dm_din  <= gnt_sel ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (state == ST_ACCESS && !lat_we) begin
            rdata <= dm_dout;
        end
    end

    // A held lock in RESP overrides the round-robin flip made at the end of ACCESS.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio <= 1'b0;
        end else if (state == ST_ACCESS) begin
            prio <= ~owner;
        end else if (state == ST_RESP && lock_own) begin
            prio <= owner;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with a behavioural data memory
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [6:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        lock0 = 1'b0, lock1 = 1'b0;
    logic        ack0, ack1, busy, dm_wr;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [6:0]  dm_addr;

    logic [31:0] mem [0:127];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef DM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) chk("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic do_txn(input vec_t v);
        req0 = ~v.port; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        req1 =  v.port; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        @(posedge clk); #1;
        @(negedge clk);
        chk("access_busy", {31'b0, busy}, 32'd1);
        chk("access_addr", {25'b0, dm_addr}, {25'b0, v.addr});
        chk("access_wr", {31'b0, dm_wr}, {31'b0, v.we});
        if (v.we) chk("access_din", dm_din, v.wdata);
        chk("access_noack", {30'b0, ack1, ack0}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_ack", {30'b0, ack1, ack0}, v.port ? 32'd2 : 32'd1);
        chk("resp_wr", {31'b0, dm_wr}, 32'd0);
        chk("resp_rdata", rdata, v.exp_rdata);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rstn = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int nack;
        logic [1:0] owners [8];
        int gaps [8];

        for (int i = 0; i < 128; i++) mem[i] = '0;
        vecs[0]  = '{0, 1, 7'h05, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{0, 0, 7'h05, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1, 1, 7'h00, 32'h11111111, 32'hDEADBEEF};
        vecs[3]  = '{1, 1, 7'h01, 32'h22222222, 32'hDEADBEEF};
        vecs[4]  = '{0, 1, 7'h02, 32'h33333333, 32'hDEADBEEF};
        vecs[5]  = '{1, 1, 7'h03, 32'h44444444, 32'hDEADBEEF};
        vecs[6]  = '{1, 0, 7'h02, 32'h0,        32'h33333333};
        vecs[7]  = '{0, 0, 7'h00, 32'h0,        32'h11111111};
        vecs[8]  = '{0, 1, 7'h7F, 32'hA5A5A5A5, 32'h11111111};
        vecs[9]  = '{1, 0, 7'h7F, 32'h0,        32'hA5A5A5A5};
        vecs[10] = '{0, 1, 7'h10, 32'h10101010, 32'hA5A5A5A5};
        vecs[11] = '{1, 1, 7'h20, 32'h20202020, 32'hA5A5A5A5};

        #2;
        chk("rst_acks", {30'b0, ack1, ack0}, 32'd0);
        chk("rst_busy_wr", {30'b0, busy, dm_wr}, 32'd0);
        chk("rst_addr", {25'b0, dm_addr}, 32'd0);
        chk("rst_din", dm_din, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) do_txn(vecs[i]);

        // Port 1 alone, four back-to-back reads with req1 held.
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'd0;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            do begin @(negedge clk); cnt++; end while (!ack1 && cnt < 8);
            chk("burst_gap", cnt, (i == 0) ? 32'd2 : 32'd3);
            case (i)
                0: chk("burst_rdata", rdata, 32'h11111111);
                1: chk("burst_rdata", rdata, 32'h22222222);
                2: chk("burst_rdata", rdata, 32'h33333333);
                default: chk("burst_rdata", rdata, 32'h44444444);
            endcase
            @(posedge clk); #1;
            if (i == 3) req1 = 1'b0; else addr1 = 7'(i + 1);
        end
        @(negedge clk);

        // Address change after grant is ignored.
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'h10;
        @(posedge clk); #1; addr1 = 7'h20;
        @(negedge clk);
        chk("latch_addr", {25'b0, dm_addr}, 32'h10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("latch_ack", {30'b0, ack1, ack0}, 32'd2);
        chk("latch_rdata", rdata, 32'h10101010);
        @(posedge clk); #1; req1 = 1'b0;
        @(negedge clk);

        // Reset mid-ACCESS on a write: strobe drops at once, never acked, memory untouched.
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'd9; wdata0 = 32'hBAD0BAD0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_wr_pre", {31'b0, dm_wr}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("abort_wr", {31'b0, dm_wr}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        req0 = 1'b0; we0 = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_noack", {29'b0, busy, ack1, ack0}, 32'd0);
        end
        chk("abort_mem", mem[9], 32'd0);
        chk("abort_rdata", rdata, 32'd0);

        // Contention from reset: grants alternate 0,1,0,1 every 3 cycles.
        pulse_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 7'd0; addr1 = 7'd1;
        nack = 0; cnt = 0;
        while (nack < 4 && cnt < 30) begin
            @(negedge clk); cnt++;
            if (ack0 | ack1) begin
                owners[nack] = {ack1, ack0};
                gaps[nack] = cnt;
                chk("cont_rdata", rdata, ack1 ? 32'h22222222 : 32'h11111111);
                nack++; cnt = 0;
            end
        end
        @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;
        chk("cont_count", nack, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_owner", {30'b0, owners[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_gap", gaps[i], (i == 0) ? 32'd2 : 32'd3);
        end
        @(negedge clk);

`ifdef DM_ARB_LOCK_EN
        // Lock on port 1 keeps it granted until released.
        pulse_reset();
        req0 = 1'b1; req1 = 1'b1; lock1 = 1'b1;
        nack = 0; cnt = 0;
        while (nack < 5 && cnt < 40) begin
            @(negedge clk); cnt++;
            if (ack0 | ack1) begin
                owners[nack] = {ack1, ack0};
                nack++; cnt = 0;
                if (nack == 4) lock1 = 1'b0;
            end
        end
        @(posedge clk); #1; req0 = 1'b0; req1 = 1'b0;
        chk("lock_count", nack, 32'd5);
        for (int i = 0; i < 5; i++)
            chk("lock_owner", {30'b0, owners[i]}, (i == 0 || i == 4) ? 32'd1 : 32'd2);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
